// File: rtl/i2c_uart_frame_scheduler.sv
// Frames 16-bit I2C parser words from the event FIFO into 3-byte UART packets and
// interleaves a periodic heartbeat/status frame carrying the FIFO drop count.
module i2c_uart_frame_scheduler #(
    parameter int unsigned HB_PERIOD = 50_000_000,
    parameter logic [7:0]  SYNC_EVT  = 8'hA5,
    parameter logic [7:0]  SYNC_STS  = 8'h5A
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic        i_fifo_empty,
    input  logic        i_fifo_full,
    input  logic        i_fifo_wr_en,
    input  logic [15:0] i_fifo_data,
    output logic        o_fifo_rd_en,
    input  logic        i_tx_busy,
    input  logic        i_tx_done,
    output logic [7:0]  o_tx_byte,
    output logic        o_tx_en,
    output logic [7:0]  o_drop_cnt,
    output logic [7:0]  o_seq,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_LAT  = 3'd2,
        S_SEND = 3'd3,
        S_WAIT = 3'd4,
        S_NEXT = 3'd5
    } state_t;

    localparam bit          HB_ON   = (HB_PERIOD != 0);
    localparam logic [31:0] HB_LAST = HB_ON ? 32'(HB_PERIOD - 1) : '0;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [23:0] frame_q, frame_d;
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  drop_q, drop_d;
    logic [31:0] hb_cnt_q, hb_cnt_d;
    logic        hb_pend_q, hb_pend_d;

    logic        sel_sts;
    logic        rd_en;
    logic        tx_en;
    logic        hb_tc;
    logic        drop_evt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            frame_q   <= '0;
            seq_q     <= '0;
            drop_q    <= '0;
            hb_cnt_q  <= '0;
            hb_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            seq_q     <= seq_d;
            drop_q    <= drop_d;
            hb_cnt_q  <= hb_cnt_d;
            hb_pend_q <= hb_pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        seq_d   = seq_q;
        sel_sts = 1'b0;
        rd_en   = 1'b0;
        tx_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Status has priority at a frame boundary; drop count is snapshotted here.
                if (i_enable && hb_pend_q) begin
                    sel_sts = 1'b1;
                    frame_d = {SYNC_STS, drop_q, seq_q};
                    idx_d   = '0;
                    state_d = S_SEND;
                end else if (i_enable && !i_fifo_empty) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                rd_en   = 1'b1;
                state_d = S_LAT;
            end
            S_LAT: begin
                frame_d = {SYNC_EVT, i_fifo_data};
                idx_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (!i_tx_busy) begin
                    tx_en   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_tx_done) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q == 2'd2) begin
                    idx_d   = '0;
                    seq_d   = seq_q + 8'd1;
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_SEND;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hb_tc     = HB_ON && (hb_cnt_q == HB_LAST);
        hb_cnt_d  = (!HB_ON || hb_tc) ? '0 : hb_cnt_q + 32'd1;
        hb_pend_d = (hb_pend_q && !sel_sts) || hb_tc;

        // A drop coinciding with the snapshot starts the new count at 1.
        drop_evt = i_fifo_wr_en && i_fifo_full;
        if (sel_sts) begin
            drop_d = {7'd0, drop_evt};
        end else if (drop_evt && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    always_comb begin
        case (idx_q)
            2'd0:    o_tx_byte = frame_q[23:16];
            2'd1:    o_tx_byte = frame_q[15:8];
            default: o_tx_byte = frame_q[7:0];
        endcase
    end

    assign o_fifo_rd_en = rd_en;
    assign o_tx_en      = tx_en;
    assign o_drop_cnt   = drop_q;
    assign o_seq        = seq_q;
    assign o_state      = state_q;

endmodule
